// File: rtl/timer_alarm_sched.sv
// timer_alarm_sched: multi-channel alarm scheduler for the shared timer count.
// Each channel compares time_i against its CMP register. A channel can fire once
// (one-shot) or reload its CMP by PERIOD on every match (periodic). Pending alarms
// are arbitrated round-robin onto a single irq_o/irq_id_o line, and the core
// acknowledges each one with irq_ack_i.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   time_i                      free-running timer count
//   cfg_valid_i/we_i/addr_i/wdata_i  single-beat cfg request, addr = {channel, reg[1:0]}
//   cfg_rdata_o, cfg_ready_o    read data and 1-cycle completion pulse
//   irq_o, irq_id_o, irq_ack_i  interrupt line, presented channel, acknowledge
module timer_alarm_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TIME_W = 32,
    parameter int unsigned CH_AW  = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [TIME_W-1:0] time_i,
    input  logic              cfg_valid_i,
    input  logic              cfg_we_i,
    input  logic [CH_AW+1:0]  cfg_addr_i,
    input  logic [TIME_W-1:0] cfg_wdata_i,
    output logic [TIME_W-1:0] cfg_rdata_o,
    output logic              cfg_ready_o,
    output logic              irq_o,
    output logic [CH_AW-1:0]  irq_id_o,
    input  logic              irq_ack_i
);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CMP    = 2'd1;
    localparam logic [1:0] REG_PERIOD = 2'd2;

    // ctrl bit1 = PERIODIC, bit0 = EN
    logic [1:0]        ctrl_q   [NUM_CH];
    logic [1:0]        ctrl_d   [NUM_CH];
    logic [TIME_W-1:0] cmp_q    [NUM_CH];
    logic [TIME_W-1:0] cmp_d    [NUM_CH];
    logic [TIME_W-1:0] period_q [NUM_CH];
    logic [TIME_W-1:0] period_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [CH_AW-1:0]  rr_q, rr_d;
    logic              irq_q, irq_d;
    logic [CH_AW-1:0]  irq_id_q, irq_id_d;
    logic              ready_q, ready_d;
    logic [TIME_W-1:0] rdata_q, rdata_d;

    logic              req_c, wr_c, ack_c;
    logic [CH_AW-1:0]  ch_sel;
    logic [1:0]        reg_sel;
    logic [TIME_W-1:0] rd_val;
    logic [NUM_CH-1:0] match, clr, arb_pend;
    logic [CH_AW-1:0]  idx;
    logic              found;

    // A request is taken only when the previous one is not completing this cycle
    assign req_c   = cfg_valid_i & ~ready_q;
    assign wr_c    = req_c & cfg_we_i;
    assign ch_sel  = cfg_addr_i[CH_AW+1:2];
    assign reg_sel = cfg_addr_i[1:0];
    assign ack_c   = irq_ack_i & irq_q;

    // Read mux; STATUS aliases into every channel
    always_comb begin
        rd_val = '0;
        case (reg_sel)
            REG_CTRL:   rd_val = TIME_W'(ctrl_q[ch_sel]);
            REG_CMP:    rd_val = cmp_q[ch_sel];
            REG_PERIOD: rd_val = period_q[ch_sel];
            default:    rd_val = TIME_W'(pend_q);
        endcase
    end

    // Compare matches and pending clears (ack plus write-1-to-clear)
    always_comb begin
        match = '0;
        clr   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            match[k] = ctrl_q[k][0] & (time_i == cmp_q[k]);
        end
        if (ack_c) begin
            clr[irq_id_q] = 1'b1;
        end
        if (wr_c && (reg_sel == 2'd3)) begin
            clr = clr | cfg_wdata_i[NUM_CH-1:0];
        end
    end

    // A fresh match wins over a clear of the same bit
    assign pend_d = (pend_q & ~clr) | match;

    // Per-channel reload / one-shot disarm; a cfg write to the same reg wins
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ctrl_d[k]   = ctrl_q[k];
            cmp_d[k]    = cmp_q[k];
            period_d[k] = period_q[k];
            if (match[k]) begin
                if (ctrl_q[k][1]) begin
                    cmp_d[k] = cmp_q[k] + period_q[k];
                end else begin
                    ctrl_d[k][0] = 1'b0;
                end
            end
            if (wr_c && (ch_sel == CH_AW'(k))) begin
                case (reg_sel)
                    REG_CTRL:   ctrl_d[k]   = cfg_wdata_i[1:0];
                    REG_CMP:    cmp_d[k]    = cfg_wdata_i;
                    REG_PERIOD: period_d[k] = cfg_wdata_i;
                    default:    ;
                endcase
            end
        end
    end

    // Round-robin pick from rr pointer; bits cleared this cycle are excluded
    always_comb begin
        arb_pend = pend_q & ~clr;
        found    = 1'b0;
        idx      = '0;
        irq_id_d = irq_id_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = rr_q + CH_AW'(i);
            if (!found && arb_pend[idx]) begin
                found    = 1'b1;
                irq_id_d = idx;
            end
        end
        irq_d   = found;
        rr_d    = ack_c ? (irq_id_q + CH_AW'(1)) : rr_q;
        ready_d = req_c;
        rdata_d = (req_c && !cfg_we_i) ? rd_val : rdata_q;
    end

    // State registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ctrl_q[k]   <= '0;
                cmp_q[k]    <= '0;
                period_q[k] <= '0;
            end
            pend_q   <= '0;
            rr_q     <= '0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            cmp_q    <= cmp_d;
            period_q <= period_d;
            pend_q   <= pend_d;
            rr_q     <= rr_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
        end
    end

    assign cfg_rdata_o = rdata_q;
    assign cfg_ready_o = ready_q;
    assign irq_o       = irq_q;
    assign irq_id_o    = irq_id_q;

endmodule

// File: tb/tb_timer_alarm_sched.sv
// Testbench for timer_alarm_sched: a vector table for the one-shot flow,
// hand sequences for periodic/wrap/round-robin/collision/reset cases, and a
// randomized phase checked every cycle against a behavioural reference model.
module tb_timer_alarm_sched;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tim;
    logic        cfg_valid;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_ready;
    logic        irq;
    logic [1:0]  irq_id;
    logic        ack;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tcur;

    timer_alarm_sched #(.NUM_CH(4), .TIME_W(32), .CH_AW(2)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .time_i      (tim),
        .cfg_valid_i (cfg_valid),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .cfg_ready_o (cfg_ready),
        .irq_o       (irq),
        .irq_id_o    (irq_id),
        .irq_ack_i   (ack)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_en  [N];
    logic        m_per [N];
    logic [31:0] m_cmp [N];
    logic [31:0] m_prd [N];
    logic [3:0]  m_pend;
    int          m_rr;
    logic        m_irq;
    int          m_id;
    logic        m_rdy;
    logic        m_rd_valid;
    logic [31:0] m_rd;

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_en[k] = 1'b0; m_per[k] = 1'b0; m_cmp[k] = '0; m_prd[k] = '0;
        end
        m_pend = '0; m_rr = 0; m_irq = 1'b0; m_id = 0;
        m_rdy = 1'b0; m_rd_valid = 1'b0; m_rd = '0;
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle
    task automatic model_update();
        logic       acc, wr;
        int         ch, rg, pick, c;
        logic [3:0] hit, clrm, cand;
        if (rst) begin
            model_reset();
            return;
        end
        acc = cfg_valid && !m_rdy;
        wr  = acc && cfg_we;
        ch  = int'(cfg_addr) / 4;
        rg  = int'(cfg_addr) % 4;
        m_rd_valid = acc && !cfg_we;
        if (m_rd_valid) begin
            case (rg)
                0:       m_rd = {30'd0, m_per[ch], m_en[ch]};
                1:       m_rd = m_cmp[ch];
                2:       m_rd = m_prd[ch];
                default: m_rd = {28'd0, m_pend};
            endcase
        end
        for (int k = 0; k < N; k++) hit[k] = m_en[k] && (tim == m_cmp[k]);
        clrm = '0;
        if (ack && m_irq) clrm[m_id] = 1'b1;
        if (wr && rg == 3) clrm = clrm | cfg_wdata[3:0];
        cand = m_pend & ~clrm;
        pick = -1;
        for (int j = 0; j < N; j++) begin
            c = (m_rr + j) % N;
            if (pick < 0 && cand[c]) pick = c;
        end
        if (ack && m_irq) m_rr = (m_id + 1) % N;
        m_irq = (pick >= 0);
        if (pick >= 0) m_id = pick;
        m_pend = cand | hit;
        for (int k = 0; k < N; k++) begin
            if (hit[k]) begin
                if (m_per[k]) m_cmp[k] = m_cmp[k] + m_prd[k];
                else          m_en[k]  = 1'b0;
            end
        end
        if (wr) begin
            case (rg)
                0:       begin m_en[ch] = cfg_wdata[0]; m_per[ch] = cfg_wdata[1]; end
                1:       m_cmp[ch] = cfg_wdata;
                2:       m_prd[ch] = cfg_wdata;
                default: ;
            endcase
        end
        m_rdy = acc;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: model steps on the edge, outputs compared 1ns later, pulses cleared
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        chk("model_ready", 32'(cfg_ready), 32'(m_rdy));
        chk("model_irq", 32'(irq), 32'(m_irq));
        if (m_irq) chk("model_irq_id", 32'(irq_id), 32'(m_id));
        if (m_rd_valid && m_rdy) chk("model_rdata", cfg_rdata, m_rd);
        cfg_valid = 1'b0; cfg_we = 1'b0; ack = 1'b0; rst = 1'b0;
        tcur = tcur + 32'd1;
        tim  = tcur;
    endtask

    task automatic set_time(input logic [31:0] t);
        tcur = t;
        tim  = t;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        tick();
    endtask

    task automatic cfg_rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
        cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        tick();
        chk({nm, "_ready"}, 32'(cfg_ready), 32'd1);
        chk(nm, cfg_rdata, exp);
        tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
    endtask

    // Wait (bounded) for irq_o; check id and that it appeared 2 cycles after the match
    task automatic wait_irq(input int id, input logic [31:0] mt, input string nm);
        int          n;
        logic [31:0] last;
        n = 0;
        last = tim;
        while (!irq && n < 300) begin
            last = tim;
            tick();
            n++;
        end
        chk({nm, "_timeout"}, 32'(irq), 32'd1);
        chk({nm, "_id"}, 32'(irq_id), 32'(id));
        chk({nm, "_latency"}, last, mt + 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] t;
        logic        v;
        logic        we;
        logic [3:0]  a;
        logic [31:0] wd;
        logic        ak;
        logic        e_rdy;
        logic        e_irq;
        logic [1:0]  e_id;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] t, input logic v, input logic we,
                                input logic [3:0] a, input logic [31:0] wd, input logic ak,
                                input logic er, input logic ei, input logic [1:0] eid,
                                input logic cr, input logic [31:0] erd);
        vec_t r;
        r.t = t; r.v = v; r.we = we; r.a = a; r.wd = wd; r.ak = ak;
        r.e_rdy = er; r.e_irq = ei; r.e_id = eid; r.chk_rd = cr; r.e_rd = erd;
        return r;
    endfunction

    vec_t tbl [12];

    initial begin
        // One-shot channel 0 at 0x15
        tbl[0]  = mk(32'h10, 1, 1, 4'h1, 32'h15, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(32'h11, 0, 0, 4'h0, 0,      0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(32'h12, 1, 1, 4'h0, 32'h1,  0, 1, 0, 0, 0, 0);
        tbl[3]  = mk(32'h13, 0, 0, 4'h0, 0,      0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(32'h14, 0, 0, 4'h0, 0,      0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(32'h15, 0, 0, 4'h0, 0,      0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(32'h16, 1, 0, 4'h0, 0,      0, 1, 1, 0, 1, 0);
        tbl[7]  = mk(32'h17, 0, 0, 4'h0, 0,      1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(32'h18, 1, 0, 4'h3, 0,      0, 1, 0, 0, 1, 0);
        tbl[9]  = mk(32'h15, 0, 0, 4'h0, 0,      0, 0, 0, 0, 0, 0);
        tbl[10] = mk(32'h16, 0, 0, 4'h0, 0,      0, 0, 0, 0, 0, 0);
        tbl[11] = mk(32'h17, 0, 0, 4'h0, 0,      0, 0, 0, 0, 0, 0);

        rst = 1'b1; cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ack = 1'b0;
        set_time(32'h0);
        model_reset();
        do_reset();
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_id", 32'(irq_id), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);

        // Test 1: table-driven one-shot
        for (int i = 0; i < 12; i++) begin
            set_time(tbl[i].t);
            cfg_valid = tbl[i].v; cfg_we = tbl[i].we; cfg_addr = tbl[i].a;
            cfg_wdata = tbl[i].wd; ack = tbl[i].ak;
            tick();
            chk($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].e_irq));
            if (tbl[i].e_irq) chk($sformatf("tbl%0d_id", i), 32'(irq_id), 32'(tbl[i].e_id));
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), cfg_rdata, tbl[i].e_rd);
        end

        // Test 2: periodic ch1
        set_time(32'h1000);
        cfg_wr(4'h5, 32'h5); cfg_wr(4'h6, 32'h10); cfg_wr(4'h4, 32'h3);
        set_time(32'h0);
        wait_irq(1, 32'h5, "per_a");  do_ack();
        wait_irq(1, 32'h15, "per_b"); do_ack();
        wait_irq(1, 32'h25, "per_c"); do_ack();
        cfg_rd(4'h5, 32'h35, "per_cmp");
        cfg_wr(4'h4, 32'h0);

        // Test 3: periodic reload across the count wrap
        set_time(32'h1000);
        cfg_wr(4'h9, 32'hFFFF_FFF8); cfg_wr(4'hA, 32'h10); cfg_wr(4'h8, 32'h3);
        set_time(32'hFFFF_FFF0);
        wait_irq(2, 32'hFFFF_FFF8, "wrap_a"); do_ack();
        cfg_rd(4'h9, 32'h8, "wrap_cmp");
        wait_irq(2, 32'h8, "wrap_b"); do_ack();

        // Test 4: round-robin order
        do_reset();
        set_time(32'h1000);
        cfg_wr(4'h1, 32'h40); cfg_wr(4'h9, 32'h40); cfg_wr(4'hD, 32'h40);
        cfg_wr(4'h0, 32'h1);  cfg_wr(4'h8, 32'h1);  cfg_wr(4'hC, 32'h1);
        set_time(32'h3C);
        wait_irq(0, 32'h40, "rr_first");
        do_ack(); chk("rr_2_irq", 32'(irq), 1); chk("rr_2_id", 32'(irq_id), 2);
        do_ack(); chk("rr_3_irq", 32'(irq), 1); chk("rr_3_id", 32'(irq_id), 3);
        do_ack(); chk("rr_done", 32'(irq), 0);
        set_time(32'h1000);
        cfg_wr(4'h1, 32'h50); cfg_wr(4'h0, 32'h1);
        set_time(32'h4C);
        wait_irq(0, 32'h50, "rr_ptr1"); do_ack();
        set_time(32'h1000);
        cfg_wr(4'h1, 32'h60); cfg_wr(4'hD, 32'h60); cfg_wr(4'h0, 32'h1); cfg_wr(4'hC, 32'h1);
        set_time(32'h5C);
        wait_irq(3, 32'h60, "rr_3_before_0");
        do_ack(); chk("rr_then0_irq", 32'(irq), 1); chk("rr_then0_id", 32'(irq_id), 0);
        do_ack(); chk("rr_end", 32'(irq), 0);

        // Test 5a: ack collides with a new match on the same channel
        set_time(32'h1000);
        cfg_wr(4'h5, 32'h80); cfg_wr(4'h6, 32'h2); cfg_wr(4'h4, 32'h3);
        set_time(32'h7C);
        wait_irq(1, 32'h80, "col_first");
        do_ack();
        chk("col_masked", 32'(irq), 0);
        tick();
        chk("col_reassert", 32'(irq), 1);
        chk("col_reassert_id", 32'(irq_id), 1);
        cfg_wr(4'h4, 32'h0);
        cfg_wr(4'h3, 32'hF);
        // Test 5b: CMP write on the match edge
        set_time(32'h1000);
        cfg_wr(4'h9, 32'h90); cfg_wr(4'h8, 32'h1);
        set_time(32'h8E);
        tick(); tick();
        cfg_valid = 1'b1; cfg_we = 1'b1; cfg_addr = 4'h9; cfg_wdata = 32'h1234;
        tick();
        tick();
        chk("cmpw_irq", 32'(irq), 1);
        chk("cmpw_id", 32'(irq_id), 2);
        cfg_rd(4'h9, 32'h1234, "cmpw_cmp");
        cfg_rd(4'h8, 32'h0, "cmpw_ctrl");
        cfg_rd(4'h3, 32'h4, "cmpw_status");
        do_ack();

        // Test 6: reset with everything pending and a request in flight
        set_time(32'h1000);
        for (int k = 0; k < N; k++) cfg_wr(4'(4 * k + 1), 32'hA0);
        for (int k = 0; k < N; k++) cfg_wr(4'(4 * k), 32'h1);
        set_time(32'h9C);
        wait_irq(3, 32'hA0, "rst_setup");
        cfg_rd(4'h3, 32'hF, "rst_pend_all");
        chk("rst_pre_irq", 32'(irq), 1);
        rst = 1'b1; cfg_valid = 1'b1; cfg_we = 1'b0; cfg_addr = 4'h3;
        tick();
        chk("rst_mid_irq", 32'(irq), 0);
        chk("rst_mid_ready", 32'(cfg_ready), 0);
        chk("rst_mid_rdata", cfg_rdata, 0);
        cfg_rd(4'h3, 32'h0, "rst_status");
        for (int k = 0; k < N; k++) begin
            cfg_rd(4'(4 * k), 32'h0, $sformatf("rst_ctrl%0d", k));
            cfg_rd(4'(4 * k + 1), 32'h0, $sformatf("rst_cmp%0d", k));
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            logic [3:0]  a;
            if ($urandom_range(0, 63) == 0) set_time(tcur - 32'd30);
            r = $urandom_range(0, 99);
            if (r < 40) begin
                a = 4'($urandom_range(0, 15));
                cfg_valid = 1'b1;
                cfg_we    = ($urandom_range(0, 3) != 0);
                cfg_addr  = a;
                case (a[1:0])
                    2'd0:    cfg_wdata = 32'($urandom_range(0, 3));
                    2'd1:    cfg_wdata = tcur + 32'($urandom_range(0, 24));
                    2'd2:    cfg_wdata = 32'($urandom_range(0, 6));
                    default: cfg_wdata = 32'($urandom_range(0, 15));
                endcase
            end
            ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 499) == 0) rst = 1'b1;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
